// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake game engine.
//   dir_t    - heading / direction request
//   cell_t   - grid cell coordinate (6-bit x, 5-bit y)
//   state_t  - move FSM state
//   Reset body, food and LFSR seed constants, plus small helpers.
package snake_pkg;

   typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

   typedef struct packed {
      logic [5:0] x;
      logic [4:0] y;
   } cell_t;

   typedef enum logic [2:0] {WAIT, CHECK, UPDATE, FOOD, DEAD} state_t;

   localparam cell_t      INIT_TAIL = '{x: 6'd18, y: 5'd15};
   localparam cell_t      INIT_MID  = '{x: 6'd19, y: 5'd15};
   localparam cell_t      INIT_HEAD = '{x: 6'd20, y: 5'd15};
   localparam cell_t      INIT_FOOD = '{x: 6'd30, y: 5'd15};
   localparam logic [6:0] INIT_LEN  = 7'd3;
   localparam logic [9:0] LFSR_SEED = 10'h2A5;

   // x^10 + x^7 + 1, Fibonacci form
   function automatic logic [9:0] lfsr_step(input logic [9:0] s);
      return {s[8:0], s[9] ^ s[6]};
   endfunction

   function automatic dir_t opposite(input dir_t d);
      case (d)
         UP:      return DOWN;
         DOWN:    return UP;
         LEFT:    return RIGHT;
         default: return LEFT;
      endcase
   endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// snake_body_fifo: circular buffer of snake body cells.
//   clk, rst_n   - clock, async active-low reset (preloads the 3 start cells)
//   push_i       - write push_cell_i as the new head
//   pop_i        - drop the tail entry
//   head_o       - newest entry (at write pointer)
//   tail_o       - oldest entry (at read pointer)
// Push and pop in the same cycle at full depth is legal: the new head lands
// in the slot the tail is leaving.
module snake_body_fifo
   import snake_pkg::*;
#(
   parameter int unsigned MAX_LEN = 64
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push_i,
   input  logic  pop_i,
   input  cell_t push_cell_i,
   output cell_t head_o,
   output cell_t tail_o
);

   localparam int unsigned PTR_W = $clog2(MAX_LEN);

   cell_t            mem_q [MAX_LEN];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
         mem_q[0] <= INIT_TAIL;
         mem_q[1] <= INIT_MID;
         mem_q[2] <= INIT_HEAD;
         wr_ptr_q <= PTR_W'(2);
         rd_ptr_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q + 1'b1] <= push_cell_i;
            wr_ptr_q               <= wr_ptr_q + 1'b1;
         end
         if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign head_o = mem_q[wr_ptr_q];
   assign tail_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/snake_engine.sv
// snake_engine: game-state engine for the VGA snake.
//   clk, reset          - pixel clock, async active-low reset
//   frame_tick          - one pulse per frame; a move step every MOVE_DIV ticks
//   btn_up/down/left/right - synchronised direction levels
//   pos_x, pos_y, display_on - beam position / active video from vga
//   snake_px, head_px, food_px - registered per-pixel hits (1-clock latency)
//   game_over           - sticky collision flag
//   length              - current segment count
module snake_engine
   import snake_pkg::*;
#(
   parameter int unsigned GRID_W    = 40,
   parameter int unsigned GRID_H    = 30,
   parameter int unsigned CELL_LOG2 = 4,
   parameter int unsigned MAX_LEN   = 64,
   parameter int unsigned MOVE_DIV  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic [9:0] pos_x,
   input  logic [9:0] pos_y,
   input  logic       display_on,
   output logic       snake_px,
   output logic       head_px,
   output logic       food_px,
   output logic       game_over,
   output logic [6:0] length
);

   localparam int unsigned CELLS = GRID_W * GRID_H;
   localparam int unsigned IDX_W = $clog2(CELLS);
   localparam int unsigned DIV_W = $clog2(MOVE_DIV + 1);

   function automatic logic [IDX_W-1:0] cell_idx(input cell_t c);
      return IDX_W'(32'(c.y) * GRID_W + 32'(c.x));
   endfunction

   state_t           state_q, state_d;
   dir_t             dir_q, dir_d, heading_q, heading_d, req;
   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       lfsr_q, lfsr_d;
   cell_t            food_q, food_d, next_q, next_d;
   logic             eat_q, eat_d;
   logic [6:0]       len_q, len_d;
   logic [CELLS-1:0] occ_q, occ_d;
   logic             snake_px_q, head_px_q, food_px_q;

   cell_t            head, tail, nxt, cand, pix_cell;
   logic             wall, push, pop, req_v, pix_in;
   logic [9:0]       col, row;

   snake_body_fifo #(.MAX_LEN(MAX_LEN)) u_body (
      .clk        (clk),
      .rst_n      (reset),
      .push_i     (push),
      .pop_i      (pop),
      .push_cell_i(next_q),
      .head_o     (head),
      .tail_o     (tail)
   );

   // Candidate next head; a step off x=0 / y=0 is caught before any wrap.
   always_comb begin
      nxt  = head;
      wall = 1'b0;
      case (dir_q)
         UP:      if (head.y == '0) wall = 1'b1; else nxt.y = head.y - 5'd1;
         DOWN:    if (head.y == 5'(GRID_H - 1)) wall = 1'b1; else nxt.y = head.y + 5'd1;
         LEFT:    if (head.x == '0) wall = 1'b1; else nxt.x = head.x - 6'd1;
         default: if (head.x == 6'(GRID_W - 1)) wall = 1'b1; else nxt.x = head.x + 6'd1;
      endcase
   end

   assign cand = '{x: lfsr_q[5:0], y: lfsr_q[9:5]};

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      heading_d = heading_q;
      div_d     = div_q;
      lfsr_d    = lfsr_step(lfsr_q);
      food_d    = food_q;
      next_d    = next_q;
      eat_d     = eat_q;
      len_d     = len_q;
      occ_d     = occ_q;
      push      = 1'b0;
      pop       = 1'b0;
      req       = dir_q;
      req_v     = 1'b1;

      // Ticks are counted in any live state, but only WAIT may launch a step.
      if (frame_tick && state_q != DEAD) begin
         if (div_q == DIV_W'(MOVE_DIV - 1)) begin
            if (state_q == WAIT) begin
               div_d   = '0;
               state_d = CHECK;
            end
         end else begin
            div_d = div_q + 1'b1;
         end
      end

      case (state_q)
         CHECK: begin
            heading_d = dir_q;
            next_d    = nxt;
            eat_d     = (nxt == food_q);
            if (wall)
               state_d = DEAD;
            else if (occ_q[cell_idx(nxt)] && !((nxt == tail) && (nxt != food_q)))
               state_d = DEAD;
            else
               state_d = UPDATE;
         end
         UPDATE: begin
            push = 1'b1;
            pop  = !eat_q || (len_q == 7'(MAX_LEN));
            if (!pop) len_d = len_q + 7'd1;
            if (pop && (tail != next_q)) occ_d[cell_idx(tail)] = 1'b0;
            occ_d[cell_idx(next_q)] = 1'b1;
            state_d = eat_q ? FOOD : WAIT;
         end
         FOOD: begin
            if (cand.x < 6'(GRID_W) && cand.y < 5'(GRID_H) && !occ_q[cell_idx(cand)]) begin
               food_d  = cand;
               state_d = WAIT;
            end
         end
         DEAD:    state_d = DEAD;
         default: ;
      endcase

      // Reverse check uses the heading the next step will start from, so a
      // request arriving during CHECK cannot fold the snake onto its neck.
      if (btn_up)         req = UP;
      else if (btn_down)  req = DOWN;
      else if (btn_left)  req = LEFT;
      else if (btn_right) req = RIGHT;
      else                req_v = 1'b0;
      if (state_q != DEAD && req_v && req != opposite(heading_d)) dir_d = req;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= WAIT;
         dir_q     <= RIGHT;
         heading_q <= RIGHT;
         div_q     <= '0;
         lfsr_q    <= LFSR_SEED;
         food_q    <= INIT_FOOD;
         next_q    <= INIT_HEAD;
         eat_q     <= 1'b0;
         len_q     <= INIT_LEN;
         occ_q     <= '0;
         occ_q[cell_idx(INIT_TAIL)] <= 1'b1;
         occ_q[cell_idx(INIT_MID)]  <= 1'b1;
         occ_q[cell_idx(INIT_HEAD)] <= 1'b1;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         heading_q <= heading_d;
         div_q     <= div_d;
         lfsr_q    <= lfsr_d;
         food_q    <= food_d;
         next_q    <= next_d;
         eat_q     <= eat_d;
         len_q     <= len_d;
         occ_q     <= occ_d;
      end
   end

   always_comb begin
      col      = pos_x >> CELL_LOG2;
      row      = pos_y >> CELL_LOG2;
      pix_in   = display_on && (col < 10'(GRID_W)) && (row < 10'(GRID_H));
      pix_cell = '{x: col[5:0], y: row[4:0]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snake_px_q <= 1'b0;
         head_px_q  <= 1'b0;
         food_px_q  <= 1'b0;
      end else begin
         snake_px_q <= pix_in && occ_q[cell_idx(pix_cell)];
         head_px_q  <= pix_in && (pix_cell == head);
         food_px_q  <= pix_in && (pix_cell == food_q);
      end
   end

   assign snake_px  = snake_px_q;
   assign head_px   = head_px_q;
   assign food_px   = food_px_q;
   assign game_over = (state_q == DEAD);
   assign length    = len_q;

endmodule

// File: tb/tb_snake_engine.sv
// tb_snake_engine: directed self-checking bench for snake_engine.
module tb_snake_engine;

   logic       clk = 1'b0;
   logic       reset, frame_tick, btn_up, btn_down, btn_left, btn_right;
   logic [9:0] pos_x, pos_y;
   logic       display_on;
   logic       snake_px, head_px, food_px, game_over;
   logic [6:0] length;

   int   n_cmp = 0;
   int   n_err = 0;
   logic p_snake, p_head, p_food;
   int   food_cnt, snake_cnt, overlap, food_x, food_y;

   snake_engine #(
      .GRID_W   (40),
      .GRID_H   (30),
      .CELL_LOG2(4),
      .MAX_LEN  (64),
      .MOVE_DIV (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .frame_tick(frame_tick),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .display_on(display_on),
      .snake_px  (snake_px),
      .head_px   (head_px),
      .food_px   (food_px),
      .game_over (game_over),
      .length    (length)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset      = 1'b0;
      frame_tick = 1'b0;
      btn_up     = 1'b0;
      btn_down   = 1'b0;
      btn_left   = 1'b0;
      btn_right  = 1'b0;
      pos_x      = '0;
      pos_y      = '0;
      display_on = 1'b0;
      repeat (3) cyc();
      reset = 1'b1;
      cyc();
   endtask

   // Eight frame ticks with the given buttons held, then idle time for FOOD.
   task automatic do_step(input logic u, input logic d, input logic l, input logic r);
      btn_up = u; btn_down = d; btn_left = l; btn_right = r;
      for (int i = 0; i < 8; i++) begin
         frame_tick = 1'b1;
         cyc();
         frame_tick = 1'b0;
         cyc();
      end
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      repeat (80) cyc();
   endtask

   task automatic probe(input int x, input int y);
      pos_x      = 10'(x * 16 + 8);
      pos_y      = 10'(y * 16 + 8);
      display_on = 1'b1;
      cyc();
      p_snake    = snake_px;
      p_head     = head_px;
      p_food     = food_px;
      display_on = 1'b0;
   endtask

   task automatic scan_grid();
      food_cnt = 0; snake_cnt = 0; overlap = 0; food_x = -1; food_y = -1;
      for (int y = 0; y < 30; y++) begin
         for (int x = 0; x < 40; x++) begin
            probe(x, y);
            if (p_food === 1'b1) begin food_cnt++; food_x = x; food_y = y; end
            if (p_snake === 1'b1) snake_cnt++;
            if (p_food === 1'b1 && p_snake === 1'b1) overlap++;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (length !== 7'd3) begin n_err++; $display("FAIL reset_len: got %0d want 3", length); end
      n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_over: got %b want 0", game_over); end
      n_cmp++; if ({snake_px, head_px, food_px} !== 3'b000) begin n_err++; $display("FAIL reset_px: got %b want 000", {snake_px, head_px, food_px}); end
      probe(20, 15);
      n_cmp++; if ({p_snake, p_head} !== 2'b11) begin n_err++; $display("FAIL reset_head: got %b want 11", {p_snake, p_head}); end
      probe(18, 15);
      n_cmp++; if ({p_snake, p_head} !== 2'b10) begin n_err++; $display("FAIL reset_tail: got %b want 10", {p_snake, p_head}); end
      probe(30, 15);
      n_cmp++; if ({p_snake, p_food} !== 2'b01) begin n_err++; $display("FAIL reset_food: got %b want 01", {p_snake, p_food}); end
      probe(21, 15);
      n_cmp++; if (p_snake !== 1'b0) begin n_err++; $display("FAIL reset_empty: got %b want 0", p_snake); end
   endtask

   task automatic test_move();
      apply_reset();
      do_step(0, 0, 0, 0);
      probe(21, 15);
      n_cmp++; if (p_head !== 1'b1) begin n_err++; $display("FAIL move_head: got %b want 1", p_head); end
      probe(18, 15);
      n_cmp++; if (p_snake !== 1'b0) begin n_err++; $display("FAIL move_tail_clr: got %b want 0", p_snake); end
      probe(19, 15);
      n_cmp++; if (p_snake !== 1'b1) begin n_err++; $display("FAIL move_body: got %b want 1", p_snake); end
      n_cmp++; if (length !== 7'd3) begin n_err++; $display("FAIL move_len: got %0d want 3", length); end
   endtask

   task automatic test_reverse();
      apply_reset();
      do_step(0, 0, 1, 0);
      n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL rev_over: got %b want 0", game_over); end
      probe(21, 15);
      n_cmp++; if (p_head !== 1'b1) begin n_err++; $display("FAIL rev_head: got %b want 1", p_head); end
   endtask

   task automatic test_priority();
      apply_reset();
      do_step(1, 1, 0, 0);
      probe(20, 14);
      n_cmp++; if (p_head !== 1'b1) begin n_err++; $display("FAIL prio_head: got %b want 1", p_head); end
      probe(18, 15);
      n_cmp++; if (p_snake !== 1'b0) begin n_err++; $display("FAIL prio_tail: got %b want 0", p_snake); end
   endtask

   task automatic test_eat();
      apply_reset();
      repeat (9) do_step(0, 0, 0, 0);
      n_cmp++; if (length !== 7'd3) begin n_err++; $display("FAIL eat_pre_len: got %0d want 3", length); end
      do_step(0, 0, 0, 0);
      n_cmp++; if (length !== 7'd4) begin n_err++; $display("FAIL eat_len: got %0d want 4", length); end
      probe(30, 15);
      n_cmp++; if (p_head !== 1'b1) begin n_err++; $display("FAIL eat_head: got %b want 1", p_head); end
      probe(27, 15);
      n_cmp++; if (p_snake !== 1'b1) begin n_err++; $display("FAIL eat_tail_kept: got %b want 1", p_snake); end
      scan_grid();
      n_cmp++; if (food_cnt != 1) begin n_err++; $display("FAIL eat_food_cnt: got %0d want 1", food_cnt); end
      n_cmp++; if (overlap != 0) begin n_err++; $display("FAIL eat_food_occ: got %0d want 0", overlap); end
      n_cmp++; if (snake_cnt != 4) begin n_err++; $display("FAIL eat_snake_cnt: got %0d want 4", snake_cnt); end
   endtask

   // Continues from test_eat: length 4 at (27..30,15) heading right.
   task automatic test_tail_chase();
      logic go_up;
      int   r;
      go_up = !(food_y == 14 && (food_x == 29 || food_x == 30));
      r     = go_up ? 14 : 16;
      do_step(go_up, !go_up, 0, 0);
      probe(30, r);
      n_cmp++; if (p_head !== 1'b1) begin n_err++; $display("FAIL loop_v1: got %b want 1", p_head); end
      do_step(0, 0, 1, 0);
      probe(29, r);
      n_cmp++; if (p_head !== 1'b1) begin n_err++; $display("FAIL loop_left: got %b want 1", p_head); end
      do_step(!go_up, go_up, 0, 0);
      n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL loop_v2_over: got %b want 0", game_over); end
      probe(29, 15);
      n_cmp++; if ({p_snake, p_head} !== 2'b11) begin n_err++; $display("FAIL loop_v2_head: got %b want 11", {p_snake, p_head}); end
      do_step(0, 0, 0, 1);
      n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL loop_right_over: got %b want 0", game_over); end
      n_cmp++; if (length !== 7'd4) begin n_err++; $display("FAIL loop_len: got %0d want 4", length); end
      probe(30, 15);
      n_cmp++; if ({p_snake, p_head} !== 2'b11) begin n_err++; $display("FAIL loop_right_head: got %b want 11", {p_snake, p_head}); end
      probe(30, r);
      n_cmp++; if (p_snake !== 1'b1) begin n_err++; $display("FAIL loop_tail: got %b want 1", p_snake); end
      probe(29, 15);
      n_cmp++; if (p_snake !== 1'b1) begin n_err++; $display("FAIL loop_body: got %b want 1", p_snake); end
   endtask

   task automatic test_wall();
      apply_reset();
      do_step(1, 0, 0, 0);
      repeat (19) do_step(0, 0, 0, 1);
      n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL wall_pre_over: got %b want 0", game_over); end
      probe(39, 14);
      n_cmp++; if (p_head !== 1'b1) begin n_err++; $display("FAIL wall_pre_head: got %b want 1", p_head); end
      do_step(0, 0, 0, 1);
      n_cmp++; if (game_over !== 1'b1) begin n_err++; $display("FAIL wall_over: got %b want 1", game_over); end
      for (int k = 0; k < 3; k++) begin
         do_step(0, 0, 0, 1);
         n_cmp++; if (game_over !== 1'b1) begin n_err++; $display("FAIL wall_sticky%0d: got %b want 1", k, game_over); end
      end
      n_cmp++; if (length !== 7'd3) begin n_err++; $display("FAIL wall_len: got %0d want 3", length); end
      probe(39, 14);
      n_cmp++; if (p_head !== 1'b1) begin n_err++; $display("FAIL wall_frozen_head: got %b want 1", p_head); end
      probe(37, 14);
      n_cmp++; if (p_snake !== 1'b1) begin n_err++; $display("FAIL wall_frozen_tail: got %b want 1", p_snake); end
   endtask

   task automatic test_pixel();
      apply_reset();
      pos_x = 10'd320; pos_y = 10'd240; display_on = 1'b1;
      #1;
      n_cmp++; if (snake_px !== 1'b0) begin n_err++; $display("FAIL pix_latency: got %b want 0", snake_px); end
      cyc();
      n_cmp++; if ({snake_px, head_px, food_px} !== 3'b110) begin n_err++; $display("FAIL pix_on: got %b want 110", {snake_px, head_px, food_px}); end
      display_on = 1'b0;
      cyc();
      n_cmp++; if ({snake_px, head_px} !== 2'b00) begin n_err++; $display("FAIL pix_off: got %b want 00", {snake_px, head_px}); end
      pos_x = 10'd480;
      cyc();
      n_cmp++; if (food_px !== 1'b0) begin n_err++; $display("FAIL pix_food_off: got %b want 0", food_px); end
      display_on = 1'b1;
      cyc();
      n_cmp++; if ({snake_px, food_px} !== 2'b01) begin n_err++; $display("FAIL pix_food_on: got %b want 01", {snake_px, food_px}); end
      display_on = 1'b0;
   endtask

   initial begin
      test_reset();
      test_pixel();
      test_move();
      test_reverse();
      test_priority();
      test_eat();
      test_tail_chase();
      test_wall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/snake_engine.md
# snake_engine

Game-state engine for the VGA snake design. It sits directly upstream of the top-level colour mux, alongside the `vga` timing generator. Once every `MOVE_DIV` frames it advances the snake on a cell grid, detects collisions and food, and maintains an occupancy bitmap. Each cycle it answers per-pixel snake, head and food queries for the current `pos_x`/`pos_y` beam position.

## Interface
Parameters:
- `GRID_W`, 40: grid columns.
- `GRID_H`, 30: grid rows.
- `CELL_LOG2`, 4: log2 of cell size in pixels (16×16 cells, so 640×480).
- `MAX_LEN`, 64: body circular-buffer depth, power of 2.
- `MOVE_DIV`, 8: frames per move step.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame, generated by the top from the vsync edge.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: level direction requests, already synchronised.
- `pos_x`, `pos_y` in 10 each: beam position from `vga`.
- `display_on` in 1: active-video flag from `vga`.
- `snake_px` out 1: beam is over a body cell (head included).
- `head_px` out 1: beam is over the head cell.
- `food_px` out 1: beam is over the food cell.
- `game_over` out 1: sticky collision flag.
- `length` out 7: current segment count.

## Operation
- Occupancy bitmap: `GRID_W*GRID_H` bits, indexed by row `pos_y>>CELL_LOG2` and column `pos_x>>CELL_LOG2`.
- Body FIFO holds cell coordinates, head at the write pointer and tail at the read pointer.
- Reset state:
  - Body is (18,15), (19,15), (20,15), head (20,15); direction RIGHT; `length`=3.
  - Food at (30,15); frame divider 0; LFSR seed 10'h2A5.
  - `game_over`=0; all pixel outputs 0.
- Direction latch, updated every cycle from the buttons:
  - Priority up > down > left > right.
  - A request for the exact reverse of the current heading is ignored.
  - The latched direction is applied only at the next move step.
- Move FSM states:
  - WAIT: count `frame_tick`s. On the `MOVE_DIV`-th tick, reset the count and go to CHECK.
  - CHECK: compute next head. Set `eat`=(next==food).
    - If next is outside the grid, go to DEAD.
    - If the next cell is occupied, go to DEAD, except when that cell is the current tail and `eat`=0 (the tail vacates this step, so this is legal).
    - Otherwise go to UPDATE.
  - UPDATE: push next head and set its bit.
    - If `eat`=0: pop tail and clear its bit. The tail clear is skipped if the tail cell equals the new head.
    - If `eat`=1 and `length`<`MAX_LEN`: no pop, `length`+1.
    - If `eat`=1 and `length`=`MAX_LEN`: pop as normal; length saturates.
    - Go to FOOD if `eat`, else WAIT.
  - FOOD: one attempt per cycle.
    - Candidate is x=`lfsr[5:0]`, y=`lfsr[9:5]`.
    - Accept if x<`GRID_W`, y<`GRID_H` and the cell is unoccupied, then go to WAIT. Otherwise step the LFSR and retry.
  - DEAD: assert `game_over` and freeze all state. Only reset leaves DEAD.
- LFSR: 10-bit, taps x^10+x^7+1, steps every cycle in every state.
- Pixel outputs:
  - Registered lookup of bitmap, head and food against the beam position.
  - All pixel outputs forced 0 when `display_on`=0.
- Coordinate arithmetic uses unsigned 6-bit x and 5-bit y. A step from x=0 left or y=0 up is detected as a wall hit before any wrap.

## Timing
- Pixel outputs have a 1-clock latency from `pos_x`/`pos_y`/`display_on`; the top delays the syncs by one clock.
- Move step takes `frame_tick`(N), CHECK at N+1, UPDATE at N+2, back in WAIT at N+3. Bitmap and `length` change at the N+2 edge.
- FOOD takes a variable number of cycles and always completes before the next frame, given a 640-pixel blanking budget.
- A `frame_tick` arriving while not in WAIT is counted but cannot start a second step.
- A button change in the same cycle as CHECK does not affect the current step.
- Reset asserted mid-step returns immediately to reset state; deassertion is synchronised by the top.

## Structure
- Package `snake_pkg`:
  - `dir_t` enum (UP, DOWN, LEFT, RIGHT).
  - `cell_t` struct {x[5:0], y[4:0]}.
  - Reset-position and food-seed constants.
  - FSM state enum.
- Sub-module `snake_body_fifo`: circular buffer of `cell_t`. Push/pop, head/tail read, depth `MAX_LEN`, async active-low reset that preloads the 3 initial cells.

## Test plan
- Reset, then 8 `frame_tick`s with no buttons: head moves to (21,15), tail cell (18,15) bit is clear, `length`=3.
- Heading RIGHT, hold `btn_left` over a step: heading stays RIGHT and the head advances by +1 x.
- Steer the head onto the food at (30,15): `length` becomes 4, the tail does not move, and the new food cell is in range and unoccupied.
- Drive the head to x=39 heading RIGHT and step: `game_over`=1 and state stays frozen over 3 further steps.
- With a length-4 loop of U, L, D, R where the head enters the vacating tail cell: no `game_over`.
- Beam at (320,240) with display on: `snake_px`=1 and `head_px`=1 one clock later. With `display_on`=0, both are 0.
